operand_fetch: RTL and testbench

Operand-fetch stage that drives the read side of the 32×32 register file and delivers both source operands to execute. It accepts a source-register pair with a valid/ready handshake and presents the read addresses to the register file, which samples them at the clock edge. It then captures the returned data one cycle later, bypassing any same-cycle writeback, and holds the operands on a valid/ready output that stays coherent with later writebacks while stalled.

---
 rtl/operand_fetch.sv | 120 ++++++++++++
 tb/tb_operand_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch: drives register-file read addresses and resolves both operands with writeback bypass.
// Latency: 2 edges from accept to out_valid; sustains 1 request/cycle while out_ready stays high.
// Backpressure: a stalled O holds and tracks writebacks, A re-reads its registers; in_ready drops only when both are full.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_tag,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs1_val,
    output logic [DATA_W-1:0] out_rs2_val,
    output logic [DATA_W-1:0] out_tag
);

    typedef struct packed {
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [DATA_W-1:0] tag;
    } req_t;

    logic              a_v;
    req_t              a_q;
    logic [ADDR_W-1:0] o_rs1;
    logic [ADDR_W-1:0] o_rs2;

    logic              adv_o;
    logic              adv_a;
    logic              accept;
    logic [DATA_W-1:0] rs1_res;
    logic [DATA_W-1:0] rs2_res;
    logic              upd1;
    logic              upd2;

    assign adv_o    = !out_valid || out_ready;
    assign adv_a    = !a_v || adv_o;
    assign in_ready = !rst && !flush && adv_a;
    assign accept   = in_valid && in_ready;

    // A stalled stage A keeps presenting its own indices so its read data stays current.
    assign rf_read_addr1 = accept ? in_rs1 : a_q.rs1;
    assign rf_read_addr2 = accept ? in_rs2 : a_q.rs2;

    always_comb begin
        rs1_res = rf_read_data1;
        rs2_res = rf_read_data2;
        if (a_q.rs1 == '0) begin
            rs1_res = '0;
        end else if (wb_we && wb_addr == a_q.rs1) begin
            rs1_res = wb_data;
        end
        if (a_q.rs2 == '0) begin
            rs2_res = '0;
        end else if (wb_we && wb_addr == a_q.rs2) begin
            rs2_res = wb_data;
        end
    end

    assign upd1 = wb_we && (wb_addr != '0) && (wb_addr == o_rs1);
    assign upd2 = wb_we && (wb_addr != '0) && (wb_addr == o_rs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_v         <= 1'b0;
            a_q         <= '0;
            out_valid   <= 1'b0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_tag     <= '0;
            o_rs1       <= '0;
            o_rs2       <= '0;
        end else if (flush) begin
            a_v       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_v     <= 1'b1;
                a_q.rs1 <= in_rs1;
                a_q.rs2 <= in_rs2;
                a_q.tag <= in_tag;
            end else if (adv_a) begin
                a_v <= 1'b0;
            end

            if (a_v && adv_o) begin
                out_valid   <= 1'b1;
                out_rs1_val <= rs1_res;
                out_rs2_val <= rs2_res;
                out_tag     <= a_q.tag;
                o_rs1       <= a_q.rs1;
                o_rs2       <= a_q.rs2;
            end else if (adv_o) begin
                out_valid <= 1'b0;
            end else begin
                // Held operands follow later writes so they match the file when finally consumed.
                if (upd1) begin
                    out_rs1_val <= wb_data;
                end
                if (upd2) begin
                    out_rs2_val <= wb_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a write-first register file model and a streaming scoreboard.
module tb_operand_fetch;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] tag;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_tag = '0;
    logic [4:0]  rf_read_addr1;
    logic [4:0]  rf_read_addr2;
    logic [31:0] rf_read_data1 = '0;
    logic [31:0] rf_read_data2 = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_tag;

    int checks = 0;
    int failures = 0;

    logic [31:0] rf_mem [32];
    req_t        sb_q [$];

    operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Register file: x0 storage is deliberately writable so a fetch that reads x0 from the file shows up.
    always @(posedge clk) begin
        if (wb_we) rf_mem[wb_addr] <= wb_data;
        rf_read_data1 <= (wb_we && wb_addr == rf_read_addr1) ? wb_data : rf_mem[rf_read_addr1];
        rf_read_data2 <= (wb_we && wb_addr == rf_read_addr2) ? wb_data : rf_mem[rf_read_addr2];
    end

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic req(input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] t);
        in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_tag = t;
    endtask

    logic [31:0] pre_dat [8];
    req_t        e;
    logic        have;
    int          sent, got, cyc;

    initial begin
        pre_dat[0] = 32'hDEAD; pre_dat[1] = 32'h01; pre_dat[2] = 32'h02; pre_dat[3] = 32'h11;
        pre_dat[4] = 32'h22;   pre_dat[5] = 32'h55; pre_dat[6] = 32'h66; pre_dat[7] = 32'h70;

        // Reset state
        tick(); tick();
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_rs1", out_rs1_val, 32'd0);
        check_eq("rst_tag", out_tag, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) wb_write(5'(i), pre_dat[i]);

        // Basic read: two-edge latency, one-cycle output pulse
        out_ready = 1'b1;
        req(5'd3, 5'd4, 32'h100);
        tick();
        in_valid = 1'b0;
        check_eq("basic_lat1", {31'd0, out_valid}, 32'd0);
        tick();
        check_eq("basic_valid", {31'd0, out_valid}, 32'd1);
        check_eq("basic_rs1", out_rs1_val, 32'h11);
        check_eq("basic_rs2", out_rs2_val, 32'h22);
        check_eq("basic_tag", out_tag, 32'h100);
        tick();
        check_eq("basic_pulse", {31'd0, out_valid}, 32'd0);

        // Bypass of a write landing in the stage-A cycle
        req(5'd5, 5'd3, 32'h104);
        tick();
        in_valid = 1'b0;
        wb_write(5'd5, 32'hCAFE);
        check_eq("byp_rs1", out_rs1_val, 32'hCAFE);
        check_eq("byp_rs2", out_rs2_val, 32'h11);

        // x0 reads stay zero despite writes in the accept and stage-A cycles
        req(5'd0, 5'd0, 32'h108);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hBEEF;
        tick();
        in_valid = 1'b0;
        wb_write(5'd0, 32'h1234);
        check_eq("x0_valid", {31'd0, out_valid}, 32'd1);
        check_eq("x0_rs1", out_rs1_val, 32'd0);
        check_eq("x0_rs2", out_rs2_val, 32'd0);
        tick();

        // Stall coherency
        out_ready = 1'b0;
        req(5'd3, 5'd7, 32'h200);
        tick();
        req(5'd4, 5'd5, 32'h204);
        check_eq("stall_rdy_a_only", {31'd0, in_ready}, 32'd1);
        tick();
        req(5'd7, 5'd7, 32'h208);
        check_eq("stall_o_rs2", out_rs2_val, 32'h70);
        check_eq("stall_full_rdy", {31'd0, in_ready}, 32'd0);
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
        tick();
        wb_addr = 5'd5; wb_data = 32'h5A;
        check_eq("stall_upd_rs2", out_rs2_val, 32'h77);
        check_eq("stall_keep_rs1", out_rs1_val, 32'h11);
        check_eq("stall_keep_valid", {31'd0, out_valid}, 32'd1);
        tick();
        wb_we = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("release_rdy", {31'd0, in_ready}, 32'd1);
        check_eq("release_tag0", out_tag, 32'h200);
        tick();
        in_valid = 1'b0;
        check_eq("release_tag1", out_tag, 32'h204);
        check_eq("release_rs1_1", out_rs1_val, 32'h22);
        check_eq("release_rs2_1", out_rs2_val, 32'h5A);
        tick();
        check_eq("release_tag2", out_tag, 32'h208);
        check_eq("release_rs1_2", out_rs1_val, 32'h77);
        check_eq("release_rs2_2", out_rs2_val, 32'h77);
        tick();
        check_eq("release_drain", {31'd0, out_valid}, 32'd0);

        // Flush with both stages full
        out_ready = 1'b0;
        req(5'd3, 5'd4, 32'h300);
        tick();
        req(5'd4, 5'd3, 32'h304);
        tick();
        req(5'd5, 5'd5, 32'h308);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        check_eq("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check_eq("flush_a_empty", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        req(5'd3, 5'd4, 32'h400);
        tick();
        req(5'd4, 5'd3, 32'h404);
        tick();
        in_valid = 1'b0;
        check_eq("mid_tag", out_tag, 32'h400);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_rdy", {31'd0, in_ready}, 32'd0);
        tick();
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_rs1", out_rs1_val, 32'd0);
        check_eq("mid_rst_rs2", out_rs2_val, 32'd0);
        check_eq("mid_rst_tag", out_tag, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("post_mid_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        req(5'd3, 5'd4, 32'h500);
        tick();
        in_valid = 1'b0;
        check_eq("post_mid_lat1", {31'd0, out_valid}, 32'd0);
        tick();
        check_eq("post_mid_rs1", out_rs1_val, 32'h11);
        check_eq("post_mid_rs2", out_rs2_val, 32'h22);
        check_eq("post_mid_tag", out_tag, 32'h500);
        tick();

        // Back-to-back stream against the architectural register state
        have = 1'b0; sent = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 400) begin
            if (!have && sent < 8) begin
                in_rs1 = 5'($urandom_range(0, 7));
                in_rs2 = 5'($urandom_range(0, 7));
                in_tag = 32'h600 + 32'(sent * 4);
                have = 1'b1;
            end
            in_valid  = have;
            out_ready = 1'($urandom_range(0, 1));
            wb_we     = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb_q.push_back('{in_rs1, in_rs2, in_tag});
                sent++;
                have = 1'b0;
            end
            if (out_valid && out_ready) begin
                check_eq("b2b_pending", {31'd0, sb_q.size() > 0}, 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_eq("b2b_tag", out_tag, e.tag);
                    check_eq("b2b_rs1", out_rs1_val, (e.rs1 == 5'd0) ? 32'd0 : rf_mem[e.rs1]);
                    check_eq("b2b_rs2", out_rs2_val, (e.rs2 == 5'd0) ? 32'd0 : rf_mem[e.rs2]);
                end
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        wb_we = 1'b0;
        check_eq("b2b_count", 32'(got), 32'd8);
        check_eq("b2b_leftover", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
